// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator for a dual-slot fetch front end.
//
// Produces the registered slot-1 fetch address, the slot-2 address (slot 1 + 4)
// and per-slot valid bits. Redirects (exception over branch) load the PC one
// cycle later. A redirect that arrives while the fetch register is stalled
// is parked in a pending register and applied when the stall releases.
//
// Ports:
//   clk           clock, all state updates on its rising edge
//   rst           synchronous active-high reset
//   flush_EX      exception/ertn redirect request
//   i_EX_target   exception redirect target
//   flush_BR      branch-mispredict redirect request
//   i_BR_target   branch redirect target
//   stall_ICache  downstream fetch register holding; PC must not advance
//   o_PC1         registered slot-1 fetch address
//   o_PC2         o_PC1 + 4
//   o_is_valid    {slot 2 valid, slot 1 valid}
//   o_fault_ADEF  misaligned-fetch fault flag
//
// Configuration:
//   PC_GEN_ALIGN_CHECK_EN  defined: misaligned targets load unmasked, raise
//                          o_fault_ADEF and freeze the PC until the next
//                          loaded redirect. Undefined: target[1:0] is forced
//                          to zero and o_fault_ADEF stays 0.

module pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_EX,
    input  logic [31:0] i_EX_target,
    input  logic        flush_BR,
    input  logic [31:0] i_BR_target,
    input  logic        stall_ICache,
    output logic [31:0] o_PC1,
    output logic [31:0] o_PC2,
    output logic [1:0]  o_is_valid,
    output logic        o_fault_ADEF
);

    typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic        pend_ex_q, pend_ex_d;
    logic        fault_q, fault_d;

    logic        live_redir;
    logic [31:0] live_tgt;
    logic        load;
    logic [31:0] load_tgt;

    assign live_redir = flush_EX | flush_BR;
    assign live_tgt   = flush_EX ? i_EX_target : i_BR_target;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        pend_ex_d  = pend_ex_q;
        fault_d    = fault_q;
        load       = 1'b0;
        load_tgt   = 32'h0;

        case (state_q)
            // One bubble cycle after reset; inputs are ignored.
            StBoot: state_d = StRun;

            StRun: begin
                if (stall_ICache) begin
                    if (live_redir) begin
                        pend_tgt_d = live_tgt;
                        pend_ex_d  = flush_EX;
                        state_d    = StHold;
                    end
                end else if (live_redir) begin
                    load     = 1'b1;
                    load_tgt = live_tgt;
                end else if (!fault_q) begin
                    // Advance to the next 8-byte-aligned pair.
                    pc_d = pc_q + (pc_q[2] ? 32'd4 : 32'd8);
                end
            end

            StHold: begin
                if (stall_ICache) begin
                    // A branch may not displace a pending exception.
                    if (flush_EX) begin
                        pend_tgt_d = i_EX_target;
                        pend_ex_d  = 1'b1;
                    end else if (flush_BR && !pend_ex_q) begin
                        pend_tgt_d = i_BR_target;
                        pend_ex_d  = 1'b0;
                    end
                end else begin
                    load       = 1'b1;
                    load_tgt   = live_redir ? live_tgt : pend_tgt_q;
                    pend_tgt_d = 32'h0;
                    pend_ex_d  = 1'b0;
                    state_d    = StRun;
                end
            end

            default: state_d = StBoot;
        endcase

        if (load) begin
`ifdef PC_GEN_ALIGN_CHECK_EN
            pc_d    = load_tgt;
            fault_d = |load_tgt[1:0];
`else
            pc_d    = {load_tgt[31:2], 2'b00};
            fault_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            pend_tgt_q <= 32'h0;
            pend_ex_q  <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            pend_ex_q  <= pend_ex_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        if (state_q == StBoot) begin
            o_is_valid = 2'b00;
        end else if (fault_q) begin
            o_is_valid = 2'b01;
        end else begin
            // Slot 2 only when it stays inside the same 8-byte pair.
            o_is_valid = {~pc_q[2], 1'b1};
        end
    end

    assign o_PC1 = pc_q;
    assign o_PC2 = pc_q + 32'd4;

`ifdef PC_GEN_ALIGN_CHECK_EN
    assign o_fault_ADEF = fault_q;
`else
    assign o_fault_ADEF = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    localparam logic [31:0] RST_PC = 32'h1C00_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_EX;
    logic [31:0] i_EX_target;
    logic        flush_BR;
    logic [31:0] i_BR_target;
    logic        stall_ICache;
    logic [31:0] o_PC1;
    logic [31:0] o_PC2;
    logic [1:0]  o_is_valid;
    logic        o_fault_ADEF;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: architectural view only (PC, boot bubble, parked redirect, fault).
    logic [31:0] m_pc = RST_PC;
    bit          m_boot = 1'b1;
    bit          m_pend = 1'b0;
    bit          m_pend_ex = 1'b0;
    logic [31:0] m_pend_tgt = 32'h0;
    bit          m_fault = 1'b0;

    pc_gen #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_EX     (flush_EX),
        .i_EX_target  (i_EX_target),
        .flush_BR     (flush_BR),
        .i_BR_target  (i_BR_target),
        .stall_ICache (stall_ICache),
        .o_PC1        (o_PC1),
        .o_PC2        (o_PC2),
        .o_is_valid   (o_is_valid),
        .o_fault_ADEF (o_fault_ADEF)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_load(input logic [31:0] t);
`ifdef PC_GEN_ALIGN_CHECK_EN
        m_pc    = t;
        m_fault = (t[1:0] != 2'b00);
`else
        m_pc    = t & 32'hFFFF_FFFC;
        m_fault = 1'b0;
`endif
    endtask

    task automatic model_edge(input bit r, input bit ex, input logic [31:0] ext,
                              input bit br, input logic [31:0] brt, input bit st);
        if (r) begin
            m_pc = RST_PC; m_boot = 1; m_pend = 0; m_pend_ex = 0; m_fault = 0;
        end else if (m_boot) begin
            m_boot = 0;
        end else if (!st) begin
            if (ex)          model_load(ext);
            else if (br)     model_load(brt);
            else if (m_pend) model_load(m_pend_tgt);
            else if (!m_fault) m_pc = m_pc + ((m_pc % 8 == 0) ? 32'd8 : 32'd4);
            m_pend = 0; m_pend_ex = 0;
        end else if (ex) begin
            m_pend = 1; m_pend_ex = 1; m_pend_tgt = ext;
        end else if (br && !(m_pend && m_pend_ex)) begin
            m_pend = 1; m_pend_ex = 0; m_pend_tgt = brt;
        end
    endtask

    // Drive one cycle of inputs, advance the model with the DUT, compare after the edge.
    task automatic step(input bit r, input bit ex, input logic [31:0] ext,
                        input bit br, input logic [31:0] brt, input bit st);
        logic [1:0] exp_valid;
        rst = r; flush_EX = ex; i_EX_target = ext;
        flush_BR = br; i_BR_target = brt; stall_ICache = st;
        @(posedge clk);
        model_edge(r, ex, ext, br, brt, st);
        #1;
        if (m_boot)       exp_valid = 2'b00;
        else if (m_fault) exp_valid = 2'b01;
        else              exp_valid = (m_pc % 8 == 0) ? 2'b11 : 2'b01;
        check("pc1", o_PC1, m_pc);
        check("pc2", o_PC2, m_pc + 32'd4);
        check("valid", {30'b0, o_is_valid}, {30'b0, exp_valid});
        check("fault", {31'b0, o_fault_ADEF}, {31'b0, m_fault});
    endtask

    task automatic idle();
        step(0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    initial begin
        // Reset and boot bubble, then sequential stepping.
        step(1, 0, 32'h0, 0, 32'h0, 0);
        step(1, 1, 32'h1234_5678, 1, 32'h0000_0040, 1);
        check("rst_pc1", o_PC1, 32'h1C00_0000);
        check("rst_pc2", o_PC2, 32'h1C00_0004);
        check("rst_valid", {30'b0, o_is_valid}, 32'h0);
        check("rst_fault", {31'b0, o_fault_ADEF}, 32'h0);
        idle();
        check("boot_exit_pc", o_PC1, 32'h1C00_0000);
        check("boot_exit_valid", {30'b0, o_is_valid}, 32'h3);
        idle();
        check("seq_pc_8", o_PC1, 32'h1C00_0008);
        idle();
        check("seq_pc_10", o_PC1, 32'h1C00_0010);

        // Branch redirect to the odd slot of a pair.
        step(0, 0, 32'h0, 1, 32'h1C00_0104, 0);
        check("br_pc1", o_PC1, 32'h1C00_0104);
        check("br_pc2", o_PC2, 32'h1C00_0108);
        check("br_valid", {30'b0, o_is_valid}, 32'h1);
        idle();
        check("br_next_pc", o_PC1, 32'h1C00_0108);
        check("br_next_valid", {30'b0, o_is_valid}, 32'h3);

        // Exception wins over branch.
        step(0, 1, 32'h1C00_8000, 1, 32'h1C00_0200, 0);
        check("ex_over_br", o_PC1, 32'h1C00_8000);

        // Redirects behind a stall; pending EX not displaced by a later BR.
        step(0, 0, 32'h0, 1, 32'h1C00_0300, 1);
        check("hold_c1", o_PC1, 32'h1C00_8000);
        step(0, 1, 32'h1C00_F000, 0, 32'h0, 1);
        check("hold_c2", o_PC1, 32'h1C00_8000);
        step(0, 0, 32'h0, 1, 32'h1C00_0400, 1);
        check("hold_c3", o_PC1, 32'h1C00_8000);
        idle();
        check("hold_release", o_PC1, 32'h1C00_F000);

        // Live redirect on the release cycle beats the pending one.
        step(0, 0, 32'h0, 1, 32'h1C00_0500, 1);
        step(0, 0, 32'h0, 1, 32'h1C00_0600, 0);
        check("live_over_pend", o_PC1, 32'h1C00_0600);

        // Wraparound.
        step(0, 0, 32'h0, 1, 32'hFFFF_FFF8, 0);
        check("wrap_pre", o_PC1, 32'hFFFF_FFF8);
        idle();
        check("wrap", o_PC1, 32'h0000_0000);

        // Misaligned target.
        step(0, 0, 32'h0, 1, 32'h1C00_0102, 0);
`ifdef PC_GEN_ALIGN_CHECK_EN
        check("mis_pc", o_PC1, 32'h1C00_0102);
        check("mis_fault", {31'b0, o_fault_ADEF}, 32'h1);
        check("mis_valid", {30'b0, o_is_valid}, 32'h1);
        idle();
        check("mis_frozen", o_PC1, 32'h1C00_0102);
`else
        check("mis_pc", o_PC1, 32'h1C00_0100);
        check("mis_fault", {31'b0, o_fault_ADEF}, 32'h0);
        idle();
        check("mis_next", o_PC1, 32'h1C00_0108);
`endif

        // Reset mid-HOLD discards the pending target.
        step(0, 0, 32'h0, 1, 32'h1C00_0700, 1);
        step(1, 0, 32'h0, 0, 32'h0, 1);
        check("rst_hold_pc", o_PC1, 32'h1C00_0000);
        idle();
        idle();
        check("rst_hold_after", o_PC1, 32'h1C00_0008);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit          r, ex, br, st;
            logic [31:0] ext, brt;
            r   = ($urandom_range(0, 199) == 0);
            st  = ($urandom_range(0, 9) < 4);
            ex  = ($urandom_range(0, 9) == 0);
            br  = ($urandom_range(0, 99) < 15);
            ext = $urandom;
            brt = $urandom;
            if ($urandom_range(0, 3) != 0) ext[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) brt[1:0] = 2'b00;
            step(r, ex, ext, br, brt, st);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
